mc_main_control: RTL and testbench
==================================

MC_MAIN_CONTROL -- requirements
Module: mc_main_control

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_MAX, default 15, meaning the maximum number of cycles spent waiting on mem_ready in one memory state.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Op, input, 6 bits: opcode field of the instruction register.
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-006 The block SHALL have these 1-bit outputs: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite.
REQ-007 The block SHALL have these 2-bit outputs: ALUSrcB, PCSrc, AluOp.
REQ-008 The block SHALL have port mem_err, output, 1 bit: a one-cycle pulse on a memory wait timeout.

Function
REQ-009 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP; all outputs SHALL be decoded from state only (MEMRD/MEMWR/FETCH strobes are additionally qualified by mem_ready).
REQ-010 AluOp encoding SHALL be: 00 add, 01 subtract, 10 use Func field; AluOp 11 SHALL never be driven.
REQ-011 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=00, PCSrc=00, and hold until mem_ready=1. In that cycle it SHALL assert IRWrite=1 and PCWrite=1, then go to DECODE.
REQ-012 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, AluOp=00 and branch on Op: 100011/101011→MEMADR, 000000→EXECUTE, 000100→BRANCH, 001000→ADDIEXEC, 000010→JUMP, any other→FETCH.
REQ-013 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, AluOp=00, then go to MEMRD if Op=100011, else MEMWR.
REQ-014 MEMRD SHALL drive IorD=1, hold until mem_ready=1, then go to MEMWB.
REQ-015 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1, then go to FETCH.
REQ-016 MEMWR SHALL drive IorD=1 and assert MemWrite=1 only in the cycle mem_ready=1, then go to FETCH.
REQ-017 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, AluOp=10 → ALUWB; ALUWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, AluOp=01, PCSrc=01, Branch=1 → FETCH.
REQ-019 ADDIEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, AluOp=00 → ADDIWB; ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
REQ-020 JUMP SHALL drive PCSrc=10, PCWrite=1 → FETCH.
REQ-021 Outputs not listed for a state SHALL be 0; AluOp SHALL be 00 in states that do not use the ALU.
REQ-022 A 4-bit-or-wider wait counter SHALL increment each cycle in FETCH/MEMRD/MEMWR while mem_ready=0, and SHALL clear on every state change.
REQ-023 When the wait counter reaches MEM_WAIT_MAX with mem_ready=0, the FSM SHALL pulse mem_err for one cycle, suppress all write strobes, and go to FETCH.
REQ-024 If mem_ready=1 in the same cycle the counter reaches MEM_WAIT_MAX, the access SHALL complete normally and no mem_err SHALL be raised.

Reset
REQ-025 When reset=1 at a clock edge, the FSM SHALL enter FETCH, clear the wait counter and deassert mem_err, regardless of the current state (including mid-wait).
REQ-026 During the reset cycle and the cycle after, no write strobe (MemWrite, RegWrite, PCWrite, IRWrite) SHALL assert unless mem_ready=1 in FETCH after reset is released.

Configuration
REQ-027 With macro MC_PERF_CNT_EN defined, the block SHALL add 32-bit outputs cycle_cnt (increments every non-reset cycle) and instr_cnt (increments on each transition into FETCH from a non-FETCH state, including timeout returns), both wrapping at 2^32 and cleared by reset.
REQ-028 Without MC_PERF_CNT_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-029 The state enum (4-bit encoding), Op constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J) and AluOp constants SHALL reside in shared package mips_pkg.
REQ-030 The block SHALL be a single module; output decoding SHALL be a combinational block inside it, with no sub-module.

Verification
REQ-031 Reset, then Op=000000 with mem_ready=1 → states FETCH, DECODE, EXECUTE (AluOp=10), ALUWB (RegWrite=1, RegDst=1), FETCH; 4 cycles per instruction.
REQ-032 Op=100011, mem_ready held low 3 cycles in MEMRD → MEMRD lasts 4 cycles, then MEMWB with MemtoReg=1; 5 states in total plus 3 wait cycles.
REQ-033 Op=000100 → BRANCH with AluOp=01, Branch=1, PCSrc=01 for exactly 1 cycle; Op=000010 → JUMP with PCWrite=1, PCSrc=10.
REQ-034 mem_ready=0 throughout MEMWR with MEM_WAIT_MAX=15 → mem_err pulses once at wait count 15, MemWrite never asserts, next state FETCH.
REQ-035 Reset asserted while in MEMRD waiting → next state FETCH, counter 0; unknown Op=111111 → DECODE returns to FETCH.
REQ-036 With MC_PERF_CNT_EN: 3 R-type instructions from reset with mem_ready=1 → instr_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state
// encoding, opcode constants and ALU operation selects.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // States that stall on mem_ready and are covered by the wait timeout.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM with a bounded memory wait.
// Optional macro MC_PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 when memory is ready
// DECODE   | register read, branch target precompute, dispatch on Op
// MEMADR   | base + offset address for lw/sw
// MEMRD    | load data read, waits for mem_ready
// MEMWB    | load data written to rt
// MEMWR    | store data write, waits for mem_ready
// EXECUTE  | R-type ALU operation (Func field)
// ALUWB    | R-type result written to rd
// BRANCH   | beq compare and conditional PC update
// ADDIEXEC | rs + immediate
// ADDIWB   | addi result written to rt
// JUMP     | PC loaded with jump target
module mc_main_control
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       Branch,
  output logic       PCWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] AluOp,
  output logic       mem_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam int WCW_RAW = $clog2(MEM_WAIT_MAX + 1);
  localparam int WCW     = (WCW_RAW < 4) ? 4 : WCW_RAW;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_WAIT_MAX);

  state_t         state;
  state_t         next_state;
  logic [WCW-1:0] wait_cnt;
  logic           timeout;
  logic           wr_ok;

  // Memory gave up on this access: count reached the limit without ready.
  assign timeout = is_mem_wait(state) && !mem_ready && (wait_cnt == WAIT_MAX);
  // Write strobes are held off while reset is asserted.
  assign wr_ok   = !reset;

  // Next-state selection from current state, opcode and memory handshake.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEXEC;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    next_state = S_MEMWB;
        else if (timeout) next_state = S_FETCH;
        else              next_state = S_MEMRD;
      end
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = (mem_ready || timeout) ? S_FETCH : S_MEMWR;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_ADDIEXEC: next_state = S_ADDIWB;
      S_ADDIWB:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // State register, wait counter and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state   <= next_state;
      mem_err <= timeout;
      // A FETCH timeout stays in FETCH, so it must clear the count explicitly.
      if ((next_state != state) || timeout)
        wait_cnt <= '0;
      else if (is_mem_wait(state) && !mem_ready)
        wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // Moore output decode; memory strobes additionally qualified by mem_ready.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    Branch   = 1'b0;
    PCWrite  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    AluOp    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready && wr_ok;
        PCWrite = mem_ready && wr_ok;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:  IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = wr_ok;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = mem_ready && wr_ok;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        AluOp   = ALUOP_FUNC;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = wr_ok;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        AluOp   = ALUOP_SUB;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = wr_ok;
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = wr_ok;
      end
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  // Free-running cycle count and count of returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((next_state == S_FETCH) && (state != S_FETCH))
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// Directed, table-driven bench for mc_main_control.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, Branch, PCWrite, mem_err;
  logic [1:0] ALUSrcB, PCSrc, AluOp;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mc_main_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .Branch(Branch), .PCWrite(PCWrite), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .AluOp(AluOp), .mem_err(mem_err)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,Branch,PCWrite}
  // then ALUSrcB, PCSrc, AluOp, mem_err
  logic [15:0] outv;
  assign outv = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 Branch, PCWrite, ALUSrcB, PCSrc, AluOp, mem_err};

  localparam logic [15:0] F_N   = {9'b000000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] F_R   = {9'b001000001, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] F_ERR = {9'b000000000, 2'b01, 2'b00, 2'b00, 1'b1};
  localparam logic [15:0] DEC   = {9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] MADR  = {9'b000000100, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] MRD   = {9'b100000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] MWB   = {9'b000011000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] MWR_R = {9'b110000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] EXE   = {9'b000000100, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [15:0] AWB   = {9'b000101000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] BRN   = {9'b000000110, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [15:0] AIWB  = {9'b000001000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [15:0] JMP   = {9'b000000001, 2'b00, 2'b10, 2'b00, 1'b0};

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Entered at #1 after a rising edge; drives, checks at negedge, advances one edge.
  task automatic step(input string name, input logic [5:0] op, input logic mr, input logic [15:0] exp);
    Op = op;
    mem_ready = mr;
    @(negedge clk);
    check16(name, outv, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    Op = R;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // FETCH with ready during reset: fetch strobes must stay low
    @(negedge clk);
    check16("reset_state", outv, F_N);
    check32("reset_wait_cnt", 32'(dut.wait_cnt), 32'd0);
`ifdef MC_PERF_CNT_EN
    check32("reset_cycle_cnt", cycle_cnt, 32'd0);
    check32("reset_instr_cnt", instr_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [5:0] op, input logic mr, input logic [15:0] exp);
    vec_t v;
    v.op = op; v.mr = mr; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    Op = R;
    mem_ready = 1'b0;

    // R-type: FETCH, DECODE, EXECUTE, ALUWB
    push(R, 1, F_R); push(R, 1, DEC); push(R, 1, EXE); push(R, 1, AWB);
    // lw with three wait cycles in MEMRD
    push(LW, 1, F_R); push(LW, 1, DEC); push(LW, 1, MADR);
    push(LW, 0, MRD); push(LW, 0, MRD); push(LW, 0, MRD); push(LW, 1, MRD);
    push(LW, 1, MWB);
    // sw after two fetch wait cycles, write completes immediately
    push(SW, 0, F_N); push(SW, 0, F_N); push(SW, 1, F_R); push(SW, 1, DEC);
    push(SW, 1, MADR); push(SW, 1, MWR_R);
    // beq, addi, j
    push(BQ, 1, F_R); push(BQ, 1, DEC); push(BQ, 1, BRN);
    push(AI, 1, F_R); push(AI, 1, DEC); push(AI, 1, MADR); push(AI, 1, AIWB);
    push(JP, 1, F_R); push(JP, 1, DEC); push(JP, 1, JMP);
    // unknown opcode returns to FETCH straight from DECODE
    push(BAD, 1, F_R); push(BAD, 1, DEC); push(BAD, 0, F_N); push(R, 1, F_R);
    push(R, 1, DEC);

    do_reset();
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].op, tbl[i].mr, tbl[i].exp);

    // Store timeout: 16 MEMWR cycles without ready, then FETCH with mem_err pulse.
    do_reset();
    step("sw_f", SW, 1, F_R);
    step("sw_d", SW, 1, DEC);
    step("sw_a", SW, 1, MADR);
    for (int k = 0; k < 16; k++) step($sformatf("sw_wait%0d", k), SW, 0, MRD);
    step("sw_timeout_err", SW, 0, F_ERR);
    step("sw_err_one_cycle", SW, 0, F_N);

    // Ready arrives exactly at the limit: normal completion, no error.
    do_reset();
    step("lw_f", LW, 1, F_R);
    step("lw_d", LW, 1, DEC);
    step("lw_a", LW, 1, MADR);
    for (int k = 0; k < 15; k++) step($sformatf("lw_wait%0d", k), LW, 0, MRD);
    step("lw_ready_at_max", LW, 1, MRD);
    step("lw_wb_no_err", LW, 1, MWB);
    step("lw_back_fetch", LW, 1, F_R);

    // Fetch timeout stays in FETCH and raises mem_err.
    do_reset();
    for (int k = 0; k < 16; k++) step($sformatf("f_wait%0d", k), R, 0, F_N);
    step("fetch_timeout_err", R, 0, F_ERR);
    step("fetch_after_err", R, 1, F_R);
    step("fetch_after_err_dec", R, 1, DEC);

    // Reset mid-wait in MEMWR with ready high: no MemWrite, back to FETCH, counter clear.
    do_reset();
    step("rst_f", SW, 1, F_R);
    step("rst_d", SW, 1, DEC);
    step("rst_a", SW, 1, MADR);
    for (int k = 0; k < 3; k++) step($sformatf("rst_wait%0d", k), SW, 0, MRD);
    check32("midwait_cnt", 32'(dut.wait_cnt), 32'd3);
    reset = 1'b1;
    step("rst_no_memwrite", SW, 1, MRD);
    check32("rst_wait_cnt_clear", 32'(dut.wait_cnt), 32'd0);
    reset = 1'b0;
    step("rst_fetch", SW, 0, F_N);

`ifdef MC_PERF_CNT_EN
    do_reset();
    for (int n = 0; n < 3; n++) begin
      step("pc_f", R, 1, F_R);
      step("pc_d", R, 1, DEC);
      step("pc_e", R, 1, EXE);
      step("pc_w", R, 1, AWB);
    end
    check32("instr_cnt", instr_cnt, 32'd3);
    check32("cycle_cnt", cycle_cnt, 32'd12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
